mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 50 +++++
 rtl/mem_access_unit_lane.sv | 68 ++++++
 rtl/mem_access_unit.sv | 135 +++++++++++++
 tb/tb_mem_access_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared pipeline definitions for the memory stage.
// Holds opcode constants, exception encodings, FSM states and the
// memory-op decode helper used by the MEM stage blocks.
package mem_access_unit_pkg;

  localparam logic [5:0] OPC_SW  = 6'b101011;
  localparam logic [5:0] OPC_SH  = 6'b101001;
  localparam logic [5:0] OPC_SB  = 6'b101000;
  localparam logic [5:0] OPC_LW  = 6'b100011;
  localparam logic [5:0] OPC_LH  = 6'b100001;
  localparam logic [5:0] OPC_LHU = 6'b100101;
  localparam logic [5:0] OPC_LB  = 6'b100000;
  localparam logic [5:0] OPC_LBU = 6'b100100;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_ADEL = 2'b01;
  localparam logic [1:0] EXC_ADES = 2'b10;

  typedef enum logic {
    IDLE,
    WAIT
  } mau_state_e;

  typedef enum logic [3:0] {
    OP_NONE,
    OP_LW,
    OP_LH,
    OP_LHU,
    OP_LB,
    OP_LBU,
    OP_SW,
    OP_SH,
    OP_SB
  } mem_op_e;

  function automatic mem_op_e decode_op(input logic [5:0] opc);
    case (opc)
      OPC_SW:  return OP_SW;
      OPC_SH:  return OP_SH;
      OPC_SB:  return OP_SB;
      OPC_LW:  return OP_LW;
      OPC_LH:  return OP_LH;
      OPC_LHU: return OP_LHU;
      OPC_LB:  return OP_LB;
      OPC_LBU: return OP_LBU;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// mem_lane_align: combinational lane steering for the MEM stage.
//   op         decoded memory operation
//   addr_lo    byte offset within the word (addr[1:0])
//   wdata      store source (rt)
//   rword      word read from the data array
//   be         byte enables for stores
//   wlane      store data replicated across lanes
//   ldata      extended load result
//   misaligned word/half access not on its natural boundary
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic [31:0] ldata,
  output logic        misaligned
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];
    byte_sel = rword[{addr_lo, 3'b000} +: 8];

    be         = '0;
    wlane      = '0;
    ldata      = '0;
    misaligned = 1'b0;

    case (op)
      OP_SW: begin
        be         = 4'b1111;
        wlane      = wdata;
        misaligned = (addr_lo != 2'b00);
      end
      OP_SH: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wlane      = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      OP_SB: begin
        be    = 4'b0001 << addr_lo;
        wlane = {4{wdata[7:0]}};
      end
      OP_LW: begin
        ldata      = rword;
        misaligned = (addr_lo != 2'b00);
      end
      OP_LH: begin
        ldata      = {{16{half_sel[15]}}, half_sel};
        misaligned = addr_lo[0];
      end
      OP_LHU: begin
        ldata      = {16'h0000, half_sel};
        misaligned = addr_lo[0];
      end
      OP_LB:  ldata = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: ldata = {24'h000000, byte_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM pipeline stage with data array, latency FSM and
// MEM/WB register.
//   clk, reset           clock, synchronous active-high reset
//   ins_M, valid_M       instruction in MEM and its live flag
//   addr_M, wdata_M      ALU byte address, forwarded store data
//   stall_o              freeze upstream pipeline registers
//   ins_W, rdata_W       MEM/WB instruction and extended load data
//   valid_W, exc_W       MEM/WB live flag and exception (AdEL/AdES)
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DM_WORDS = 1024,
  parameter int LAT      = 1,
  parameter int EXC_EN   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ins_M,
  input  logic        valid_M,
  input  logic [31:0] addr_M,
  input  logic [31:0] wdata_M,
  output logic        stall_o,
  output logic [31:0] ins_W,
  output logic [31:0] rdata_W,
  output logic        valid_W,
  output logic [1:0]  exc_W
);

  localparam int         IDX_W    = $clog2(DM_WORDS);
  localparam logic [1:0] CNT_LOAD = 2'(LAT - 1);

  logic [31:0] mem [DM_WORDS];

  mem_op_e          op;
  logic             is_mem, is_store, is_load;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rword, wlane, ldata;
  logic [3:0]       be;
  logic             misaligned, out_of_range, exc_hit, mem_go;
  logic [1:0]       exc_d;

  mau_state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       stall, complete;

  assign op       = decode_op(ins_M[31:26]);
  assign is_mem   = (op != OP_NONE);
  assign is_store = op inside {OP_SW, OP_SH, OP_SB};
  assign is_load  = is_mem && !is_store;
  assign idx      = addr_M[IDX_W+1:2];
  assign rword    = mem[idx];

  mem_lane_align u_lane (
    .op         (op),
    .addr_lo    (addr_M[1:0]),
    .wdata      (wdata_M),
    .rword      (rword),
    .be         (be),
    .wlane      (wlane),
    .ldata      (ldata),
    .misaligned (misaligned)
  );

  assign out_of_range = ({2'b00, addr_M[31:2]} >= 32'(DM_WORDS));
  assign exc_hit      = (EXC_EN != 0) && valid_M && is_mem && (misaligned || out_of_range);
  assign mem_go       = valid_M && is_mem && !exc_hit;
  assign exc_d        = exc_hit ? (is_store ? EXC_ADES : EXC_ADEL) : EXC_NONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The issue cycle counts as the first latency cycle, so a LAT-cycle
  // access stalls LAT-1 cycles and completes in the WAIT cycle whose
  // decrement brings the counter to zero.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_go && (LAT > 1)) begin
          stall   = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end else begin
          complete = mem_go;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_d != '0) begin
          stall = 1'b1;
        end else begin
          complete = mem_go;
          state_d  = IDLE;
        end
      end
    endcase
  end

  assign stall_o = stall && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DM_WORDS; i++) mem[IDX_W'(i)] <= '0;
    end else if (complete && is_store) begin
      for (int unsigned l = 0; l < 4; l++) begin
        if (be[2'(l)]) mem[idx][8*l +: 8] <= wlane[8*l +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || stall_o) begin
      ins_W   <= '0;
      rdata_W <= '0;
      valid_W <= 1'b0;
      exc_W   <= EXC_NONE;
    end else begin
      ins_W   <= ins_M;
      valid_W <= valid_M;
      rdata_W <= (complete && is_load) ? ldata : '0;
      exc_W   <= exc_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam logic [5:0] T_SW  = 6'b101011;
  localparam logic [5:0] T_SH  = 6'b101001;
  localparam logic [5:0] T_SB  = 6'b101000;
  localparam logic [5:0] T_LW  = 6'b100011;
  localparam logic [5:0] T_LH  = 6'b100001;
  localparam logic [5:0] T_LHU = 6'b100101;
  localparam logic [5:0] T_LB  = 6'b100000;
  localparam logic [5:0] T_LBU = 6'b100100;
  localparam logic [5:0] T_NOP = 6'b000000;
  localparam logic [5:0] T_ADD = 6'b001000;
  localparam logic [1:0] E_NO  = 2'b00;
  localparam logic [1:0] E_LD  = 2'b01;
  localparam logic [1:0] E_ST  = 2'b10;

  typedef struct {
    int          id;
    logic [31:0] ins;
    logic [31:0] rdata;
    logic [1:0]  exc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst     [4];
  logic [31:0] ins_M   [4];
  logic        valid_M [4];
  logic [31:0] addr_M  [4];
  logic [31:0] wdata_M [4];
  logic        stall_o [4];
  logic [31:0] ins_W   [4];
  logic [31:0] rdata_W [4];
  logic        valid_W [4];
  logic [1:0]  exc_W   [4];

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   seq    = 1;

  always #5 clk = ~clk;

  mem_access_unit #(.DM_WORDS(1024), .LAT(1), .EXC_EN(1)) u_a (
    .clk(clk), .reset(rst[0]), .ins_M(ins_M[0]), .valid_M(valid_M[0]),
    .addr_M(addr_M[0]), .wdata_M(wdata_M[0]), .stall_o(stall_o[0]),
    .ins_W(ins_W[0]), .rdata_W(rdata_W[0]), .valid_W(valid_W[0]), .exc_W(exc_W[0]));

  mem_access_unit #(.DM_WORDS(1024), .LAT(3), .EXC_EN(1)) u_b (
    .clk(clk), .reset(rst[1]), .ins_M(ins_M[1]), .valid_M(valid_M[1]),
    .addr_M(addr_M[1]), .wdata_M(wdata_M[1]), .stall_o(stall_o[1]),
    .ins_W(ins_W[1]), .rdata_W(rdata_W[1]), .valid_W(valid_W[1]), .exc_W(exc_W[1]));

  mem_access_unit #(.DM_WORDS(16), .LAT(1), .EXC_EN(1)) u_c (
    .clk(clk), .reset(rst[2]), .ins_M(ins_M[2]), .valid_M(valid_M[2]),
    .addr_M(addr_M[2]), .wdata_M(wdata_M[2]), .stall_o(stall_o[2]),
    .ins_W(ins_W[2]), .rdata_W(rdata_W[2]), .valid_W(valid_W[2]), .exc_W(exc_W[2]));

  mem_access_unit #(.DM_WORDS(16), .LAT(1), .EXC_EN(0)) u_d (
    .clk(clk), .reset(rst[3]), .ins_M(ins_M[3]), .valid_M(valid_M[3]),
    .addr_M(addr_M[3]), .wdata_M(wdata_M[3]), .stall_o(stall_o[3]),
    .ins_W(ins_W[3]), .rdata_W(rdata_W[3]), .valid_W(valid_W[3]), .exc_W(exc_W[3]));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  // Issue one instruction, hold it through any stall, return after the
  // completion edge (+1) so the next call can go back to back.
  task automatic issue(input int id, input logic [5:0] opc, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic [1:0] exp_exc, input int exp_stall);
    logic [31:0] ins;
    exp_t e;
    int n;
    ins = {opc, 5'd3, 5'd4, 16'(seq)};
    seq++;
    ins_M[id]   = ins;
    valid_M[id] = 1'b1;
    addr_M[id]  = addr;
    wdata_M[id] = wd;
    e.id = id; e.ins = ins; e.rdata = exp_rd; e.exc = exp_exc;
    sb_q.push_back(e);
    n = 0;
    @(negedge clk);
    while (stall_o[id]) begin
      n++;
      if (n > 8) begin
        errors++;
        checks++;
        $display("FAIL stall_timeout dut%0d ins=%h", id, ins);
        break;
      end
      @(negedge clk);
      chk($sformatf("bubble_valid dut%0d", id), {31'd0, valid_W[id]}, 32'd0);
      chk($sformatf("bubble_ins dut%0d", id), ins_W[id], 32'd0);
    end
    chk($sformatf("stall_cycles dut%0d ins=%h", id, ins), 32'(n), 32'(exp_stall));
    @(posedge clk);
    #1;
    valid_M[id] = 1'b0;
    ins_M[id]   = '0;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (valid_W[i]) begin
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_wb dut%0d ins=%h rdata=%h exc=%b", i, ins_W[i], rdata_W[i], exc_W[i]);
        end else begin
          e = sb_q.pop_front();
          if (e.id != i || ins_W[i] !== e.ins || rdata_W[i] !== e.rdata || exc_W[i] !== e.exc) begin
            errors++;
            $display("FAIL wb_out dut%0d got ins=%h rdata=%h exc=%b expected dut%0d ins=%h rdata=%h exc=%b",
                     i, ins_W[i], rdata_W[i], exc_W[i], e.id, e.ins, e.rdata, e.exc);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; ins_M[i] = '0; valid_M[i] = 1'b0; addr_M[i] = '0; wdata_M[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_valid dut%0d", i), {31'd0, valid_W[i]}, 32'd0);
      chk($sformatf("rst_ins dut%0d", i), ins_W[i], 32'd0);
      chk($sformatf("rst_rdata dut%0d", i), rdata_W[i], 32'd0);
      chk($sformatf("rst_exc_stall dut%0d", i), {29'd0, stall_o[i], exc_W[i]}, 32'd0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;

    // Single-cycle instance: store/load, lanes, extension, exceptions.
    issue(0, T_SW,  32'h10, 32'h12345678, 32'h0,        E_NO, 0);
    issue(0, T_LW,  32'h10, 32'h0,        32'h12345678, E_NO, 0);
    issue(0, T_SB,  32'h13, 32'h000000AB, 32'h0,        E_NO, 0);
    issue(0, T_LB,  32'h13, 32'h0,        32'hFFFFFFAB, E_NO, 0);
    issue(0, T_LBU, 32'h13, 32'h0,        32'h000000AB, E_NO, 0);
    issue(0, T_LW,  32'h10, 32'h0,        32'hAB345678, E_NO, 0);
    issue(0, T_LB,  32'h10, 32'h0,        32'h00000078, E_NO, 0);
    issue(0, T_LBU, 32'h12, 32'h0,        32'h00000034, E_NO, 0);
    issue(0, T_SH,  32'h12, 32'h0000BEEF, 32'h0,        E_NO, 0);
    issue(0, T_LH,  32'h12, 32'h0,        32'hFFFFBEEF, E_NO, 0);
    issue(0, T_LHU, 32'h12, 32'h0,        32'h0000BEEF, E_NO, 0);
    issue(0, T_LH,  32'h10, 32'h0,        32'h00005678, E_NO, 0);
    issue(0, T_SH,  32'h21, 32'h00001234, 32'h0,        E_ST, 0);
    issue(0, T_LW,  32'h20, 32'h0,        32'h0,        E_NO, 0);
    issue(0, T_LW,  32'h22, 32'h0,        32'h0,        E_LD, 0);
    issue(0, T_LHU, 32'h23, 32'h0,        32'h0,        E_LD, 0);
    issue(0, T_LW,  32'h1000, 32'h0,      32'h0,        E_LD, 0);
    issue(0, T_SB,  32'h1000, 32'hFF,     32'h0,        E_ST, 0);
    issue(0, T_LW,  32'h0,  32'h0,        32'h0,        E_NO, 0);
    issue(0, T_LW,  32'hFFC, 32'h0,       32'h0,        E_NO, 0);
    issue(0, T_NOP, 32'h3,  32'hFFFF,     32'h0,        E_NO, 0);
    issue(0, T_ADD, 32'h1001, 32'h5,      32'h0,        E_NO, 0);

    // Bubble carrying a store must neither write nor stall.
    ins_M[0] = {T_SW, 26'h0}; addr_M[0] = 32'h30; wdata_M[0] = 32'hFFFFFFFF; valid_M[0] = 1'b0;
    @(negedge clk);
    chk("bubble_no_stall", {31'd0, stall_o[0]}, 32'd0);
    @(posedge clk);
    #1;
    issue(0, T_LW,  32'h30, 32'h0,        32'h0,        E_NO, 0);

    // Three-cycle latency instance.
    issue(1, T_SW,  32'h44, 32'hCAFEF00D, 32'h0,        E_NO, 2);
    issue(1, T_LW,  32'h44, 32'h0,        32'hCAFEF00D, E_NO, 2);
    issue(1, T_LB,  32'h47, 32'h0,        32'hFFFFFFCA, E_NO, 2);
    issue(1, T_LHU, 32'h46, 32'h0,        32'h0000CAFE, E_NO, 2);
    issue(1, T_LW,  32'h45, 32'h0,        32'h0,        E_LD, 0);
    issue(1, T_SW,  32'h1000, 32'h1,      32'h0,        E_ST, 0);
    issue(1, T_NOP, 32'h0,  32'h0,        32'h0,        E_NO, 0);
    issue(1, T_LW,  32'h44, 32'h0,        32'hCAFEF00D, E_NO, 2);

    // Reset in the first WAIT cycle aborts a pending store.
    ins_M[1] = {T_SW, 26'h0}; addr_M[1] = 32'h40; wdata_M[1] = 32'hDEADBEEF; valid_M[1] = 1'b1;
    @(negedge clk);
    chk("abort_issue_stall", {31'd0, stall_o[1]}, 32'd1);
    @(posedge clk);
    #1;
    rst[1] = 1'b1;
    @(negedge clk);
    chk("abort_stall_in_reset", {31'd0, stall_o[1]}, 32'd0);
    @(posedge clk);
    #1;
    rst[1] = 1'b0; valid_M[1] = 1'b0; ins_M[1] = '0;
    @(negedge clk);
    chk("abort_idle_stall", {31'd0, stall_o[1]}, 32'd0);
    chk("abort_valid_w", {31'd0, valid_W[1]}, 32'd0);
    @(posedge clk);
    #1;
    issue(1, T_LW,  32'h40, 32'h0,        32'h0,        E_NO, 2);
    issue(1, T_LW,  32'h44, 32'h0,        32'h0,        E_NO, 2);

    // Small array, exceptions enabled: range boundary.
    issue(2, T_SW,  32'h40, 32'h11111111, 32'h0,        E_ST, 0);
    issue(2, T_LW,  32'h0,  32'h0,        32'h0,        E_NO, 0);
    issue(2, T_SW,  32'h3C, 32'h00000077, 32'h0,        E_NO, 0);
    issue(2, T_LW,  32'h3C, 32'h0,        32'h00000077, E_NO, 0);

    // Small array, exceptions disabled: address truncates to the index.
    issue(3, T_SW,  32'h40, 32'h55AA55AA, 32'h0,        E_NO, 0);
    issue(3, T_LW,  32'h0,  32'h0,        32'h55AA55AA, E_NO, 0);
    issue(3, T_LW,  32'h2,  32'h0,        32'h55AA55AA, E_NO, 0);
    issue(3, T_LH,  32'h1,  32'h0,        32'h000055AA, E_NO, 0);

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
